mopshub_power_init_seq: RTL and testbench

- Power-up sequencer for the CAN buses of the 16-bus MOPSHUB core.
- Runs on start_init. For each enabled bus it issues a power-on SPI frame to the power board, waits for supply settling, and optionally triggers MOPS oscillator trimming.
- Drives power_bus_cnt, set_power_init, start_trim_ack and end_power_init, which the bridge controller and the top-level environment consume.
- Sits between the init controller (upstream) and the power SPI master / trim logic (downstream).

---
 rtl/mopshub_power_init_seq.sv | 153 +++++++++++++++
 tb/tb_mopshub_power_init_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mopshub_power_init_seq.sv
// Power-up sequencer for the MOPSHUB CAN buses: per enabled bus it sends a power-on SPI
// frame, waits for the supply to settle and optionally requests oscillator trimming.
module mopshub_power_init_seq #(
   parameter int unsigned MAX_BUSES      = 16,
   parameter int unsigned SETTLE_CYCLES  = 400,
   parameter int unsigned TIMEOUT_CYCLES = 40000,
   parameter logic [6:0]  CMD_POWER_ON   = 7'h01
) (
   input  logic        clk_40_m,
   input  logic        rst,
   input  logic        start_init,
   input  logic [4:0]  n_buses,
   input  logic        osc_auto_trim,
   input  logic        spi_ack,
   input  logic        trim_done,
   output logic [4:0]  power_bus_cnt,
   output logic        set_power_init,
   output logic        spi_req,
   output logic [75:0] data_tra_power_spi,
   output logic        start_trim_ack,
   output logic        end_power_init,
   output logic [15:0] power_fail_mask,
   output logic        busy
);

   localparam int unsigned BUS_W     = 5;
   localparam int unsigned WAIT_W    = 16;
   localparam int unsigned MASK_W    = 16;
   localparam int unsigned FRAME_W   = 76;
   localparam int unsigned PAYLOAD_W = 64;

   localparam logic [WAIT_W-1:0] SETTLE_LAST  = WAIT_W'(SETTLE_CYCLES - 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BUS_W-1:0]  BUS_MAX      = BUS_W'(MAX_BUSES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SPI_REQ   = 3'd1,
      SETTLE    = 3'd2,
      TRIM_REQ  = 3'd3,
      TRIM_WAIT = 3'd4,
      NEXT      = 3'd5,
      DONE      = 3'd6
   } state_t;

   state_t              state, state_nxt;
   logic [BUS_W-1:0]    n_eff, n_eff_nxt, cnt_nxt, n_clamp;
   logic                trim_en, trim_en_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic [MASK_W-1:0]   mask_nxt, fail_bit;

   logic                spi_req_c, start_trim_ack_c, end_power_init_c, busy_c;
   logic [FRAME_W-1:0]  frame_c;

   assign n_clamp  = (n_buses > BUS_MAX) ? BUS_MAX : n_buses;
   assign fail_bit = MASK_W'(1) << power_bus_cnt;

   // State, datapath and output registers
   always_ff @(posedge clk_40_m) begin
      if (!rst) begin
         state              <= IDLE;
         n_eff              <= '0;
         trim_en            <= 1'b0;
         wait_cnt           <= '0;
         power_bus_cnt      <= '0;
         power_fail_mask    <= '0;
         spi_req            <= 1'b0;
         data_tra_power_spi <= '0;
         start_trim_ack     <= 1'b0;
         end_power_init     <= 1'b0;
         set_power_init     <= 1'b0;
         busy               <= 1'b0;
      end else begin
         state              <= state_nxt;
         n_eff              <= n_eff_nxt;
         trim_en            <= trim_en_nxt;
         wait_cnt           <= wait_nxt;
         power_bus_cnt      <= cnt_nxt;
         power_fail_mask    <= mask_nxt;
         spi_req            <= spi_req_c;
         data_tra_power_spi <= frame_c;
         start_trim_ack     <= start_trim_ack_c;
         end_power_init     <= end_power_init_c;
         set_power_init     <= busy_c;
         busy               <= busy_c;
      end
   end

   // Next-state and datapath update; ack/done win over a simultaneous timeout
   always_comb begin
      state_nxt   = state;
      n_eff_nxt   = n_eff;
      trim_en_nxt = trim_en;
      cnt_nxt     = power_bus_cnt;
      mask_nxt    = power_fail_mask;
      unique case (state)
         IDLE: begin
            if (start_init) begin
               n_eff_nxt   = n_clamp;
               trim_en_nxt = osc_auto_trim;
               cnt_nxt     = '0;
               mask_nxt    = '0;
               state_nxt   = (n_clamp == '0) ? DONE : SPI_REQ;
            end
         end
         SPI_REQ: begin
            if (spi_ack) begin
               state_nxt = SETTLE;
            end else if (wait_cnt == TIMEOUT_LAST) begin
               mask_nxt  = power_fail_mask | fail_bit;
               state_nxt = NEXT;
            end
         end
         SETTLE: begin
            if (wait_cnt == SETTLE_LAST) state_nxt = trim_en ? TRIM_REQ : NEXT;
         end
         TRIM_REQ: state_nxt = TRIM_WAIT;
         TRIM_WAIT: begin
            if (trim_done) begin
               state_nxt = NEXT;
            end else if (wait_cnt == TIMEOUT_LAST) begin
               mask_nxt  = power_fail_mask | fail_bit;
               state_nxt = NEXT;
            end
         end
         NEXT: begin
            if (power_bus_cnt == n_eff - BUS_W'(1)) begin
               state_nxt = DONE;
            end else begin
               cnt_nxt   = power_bus_cnt + BUS_W'(1);
               state_nxt = SPI_REQ;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state)  wait_nxt = '0;
      else if (wait_cnt == '1) wait_nxt = wait_cnt;
      else                     wait_nxt = wait_cnt + WAIT_W'(1);
   end

   // Output decode: request/trim follow the next state so spi_req drops the cycle after
   // spi_ack; end pulse follows the current state, giving SETTLE_CYCLES + k + 4 latency.
   always_comb begin
      spi_req_c        = (state_nxt == SPI_REQ);
      start_trim_ack_c = (state_nxt == TRIM_REQ);
      busy_c           = (state_nxt != IDLE);
      end_power_init_c = (state == DONE);
      frame_c          = '0;
      if (spi_req_c) frame_c = {cnt_nxt, CMD_POWER_ON, PAYLOAD_W'(0)};
   end

endmodule

// File: tb/tb_mopshub_power_init_seq.sv
// Directed bench for mopshub_power_init_seq: table of sequencing scenarios with a
// per-cycle SPI/trim responder, plus hand-written reset and idle-input sequences.
`timescale 1ns/1ps
module tb_mopshub_power_init_seq;

   localparam int S      = 400;
   localparam int TO     = 40000;
   localparam int BUDGET = 60000;
   localparam int NVEC   = 9;

   logic        clk_40_m = 1'b0;
   logic        rst = 1'b0;
   logic        start_init = 1'b0;
   logic [4:0]  n_buses = '0;
   logic        osc_auto_trim = 1'b0;
   logic        spi_ack = 1'b0;
   logic        trim_done = 1'b0;
   logic [4:0]  power_bus_cnt;
   logic        set_power_init;
   logic        spi_req;
   logic [75:0] data_tra_power_spi;
   logic        start_trim_ack;
   logic        end_power_init;
   logic [15:0] power_fail_mask;
   logic        busy;

   always #12.5 clk_40_m = ~clk_40_m;

   mopshub_power_init_seq dut (
      .clk_40_m           (clk_40_m),
      .rst                (rst),
      .start_init         (start_init),
      .n_buses            (n_buses),
      .osc_auto_trim      (osc_auto_trim),
      .spi_ack            (spi_ack),
      .trim_done          (trim_done),
      .power_bus_cnt      (power_bus_cnt),
      .set_power_init     (set_power_init),
      .spi_req            (spi_req),
      .data_tra_power_spi (data_tra_power_spi),
      .start_trim_ack     (start_trim_ack),
      .end_power_init     (end_power_init),
      .power_fail_mask    (power_fail_mask),
      .busy               (busy)
   );

   typedef struct {
      logic [4:0]  n;
      logic        trim;
      int          ack_dly;
      int          hold_bus;
      int          trim_dly;
      int          stray_cyc;
      logic [15:0] exp_mask;
      int          exp_frames;
      int          exp_trims;
      int          exp_lat;
   } vec_t;

   vec_t tbl [NVEC];
   int   n_vec = 0;
   int   n_err = 0;
   int   cur_vec = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL v%0d %s: got 'h%0h, expected 'h%0h", cur_vec, name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] n, input logic trim, input int ack_dly,
                               input int hold_bus, input int trim_dly, input int stray_cyc,
                               input logic [15:0] exp_mask, input int exp_frames,
                               input int exp_trims, input int exp_lat);
      vec_t v;
      v.n = n; v.trim = trim; v.ack_dly = ack_dly; v.hold_bus = hold_bus;
      v.trim_dly = trim_dly; v.stray_cyc = stray_cyc; v.exp_mask = exp_mask;
      v.exp_frames = exp_frames; v.exp_trims = exp_trims; v.exp_lat = exp_lat;
      return v;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, " spi_req"},        64'(spi_req), 64'd0);
      chk({tag, " frame_hi"},       64'(data_tra_power_spi[75:64]), 64'd0);
      chk({tag, " frame_lo"},       data_tra_power_spi[63:0], 64'd0);
      chk({tag, " fail_mask"},      64'(power_fail_mask), 64'd0);
      chk({tag, " bus_cnt"},        64'(power_bus_cnt), 64'd0);
      chk({tag, " set_power_init"}, 64'(set_power_init), 64'd0);
      chk({tag, " busy"},           64'(busy), 64'd0);
      chk({tag, " end_power_init"}, 64'(end_power_init), 64'd0);
      chk({tag, " start_trim_ack"}, 64'(start_trim_ack), 64'd0);
   endtask

   // Runs one scenario; cycle 0 is the cycle in which start_init is driven.
   task automatic run_vec(input vec_t v);
      int cyc, ack_due, trim_due, ack_cyc, end_cyc, req_len, frames, trims;
      logic prev_req, prev_trim;
      bit ended, bad_inv;
      @(negedge clk_40_m);
      n_buses = v.n; osc_auto_trim = v.trim; start_init = 1'b1;
      @(negedge clk_40_m);
      start_init = 1'b0; n_buses = 5'd7; osc_auto_trim = ~v.trim;
      cyc = 1; ack_due = -1; trim_due = -1; ack_cyc = 0; end_cyc = 0;
      req_len = 0; frames = 0; trims = 0; prev_req = 1'b0; prev_trim = 1'b0;
      ended = 1'b0; bad_inv = 1'b0;
      while (!ended && cyc < BUDGET) begin
         spi_ack = 1'b0; trim_done = 1'b0; start_init = 1'b0;
         if (spi_req && !prev_req) begin
            chk("frame bus index", 64'(data_tra_power_spi[75:71]), 64'(frames));
            chk("frame command", 64'(data_tra_power_spi[70:64]), 64'h01);
            chk("frame payload", data_tra_power_spi[63:0], 64'd0);
            chk("bus_cnt at req", 64'(power_bus_cnt), 64'(frames));
            if (frames != v.hold_bus) ack_due = cyc + v.ack_dly;
            req_len = 0;
            frames++;
         end
         if (spi_req) req_len++;
         if (!spi_req && prev_req)
            chk("spi_req length", 64'(req_len), 64'((frames - 1 == v.hold_bus) ? TO : v.ack_dly + 1));
         if (cyc == ack_due) begin spi_ack = 1'b1; ack_cyc = cyc; end
         if (start_trim_ack) begin
            if (prev_trim) bad_inv = 1'b1;
            else begin
               chk("trim after ack", 64'(cyc - ack_cyc), 64'(S + 1));
               trim_due = cyc + v.trim_dly;
            end
            trims++;
         end
         if (cyc == trim_due) trim_done = 1'b1;
         if (cyc == v.stray_cyc) begin start_init = 1'b1; n_buses = 5'd9; end
         if ((spi_req || start_trim_ack) && !set_power_init) bad_inv = 1'b1;
         if (end_power_init) begin
            ended = 1'b1; end_cyc = cyc;
            chk("set_power_init at end", 64'(set_power_init), 64'd0);
         end
         prev_req = spi_req; prev_trim = start_trim_ack;
         if (!ended) begin @(negedge clk_40_m); cyc++; end
      end
      spi_ack = 1'b0; trim_done = 1'b0; start_init = 1'b0;
      chk("end_power_init seen", 64'(ended), 64'd1);
      chk("frames", 64'(frames), 64'(v.exp_frames));
      chk("trim pulse cycles", 64'(trims), 64'(v.exp_trims));
      chk("fail mask", 64'(power_fail_mask), 64'(v.exp_mask));
      chk("invariants", 64'(bad_inv), 64'd0);
      if (v.exp_frames > 0) chk("last bus_cnt", 64'(power_bus_cnt), 64'(v.exp_frames - 1));
      if (v.exp_lat > 0) chk("end latency", 64'(end_cyc), 64'(v.exp_lat));
      @(negedge clk_40_m);
      chk("end pulse width", 64'(end_power_init), 64'd0);
      chk("busy after done", 64'(busy), 64'd0);
      chk("mask held", 64'(power_fail_mask), 64'(v.exp_mask));
   endtask

   initial begin
      int ack_due;
      logic prev;
      bit got;
      //           n     trim ack  hold trim stray mask     fr  tr  lat
      tbl[0] = mk(5'd3,  1'b0, 10, -1,  0,  -1, 16'h0000, 3,  0,  0);
      tbl[1] = mk(5'd2,  1'b1, 5,  -1,  50, -1, 16'h0000, 2,  2,  0);
      tbl[2] = mk(5'd4,  1'b0, 3,  2,   0,  -1, 16'h0004, 4,  0,  0);
      tbl[3] = mk(5'd0,  1'b0, 0,  -1,  0,  -1, 16'h0000, 0,  0,  2);
      tbl[4] = mk(5'd20, 1'b0, 2,  -1,  0,  -1, 16'h0000, 16, 0,  0);
      tbl[5] = mk(5'd1,  1'b0, 0,  -1,  0,  -1, 16'h0000, 1,  0,  S + 4);
      tbl[6] = mk(5'd1,  1'b0, 7,  -1,  0,  -1, 16'h0000, 1,  0,  S + 11);
      tbl[7] = mk(5'd2,  1'b0, 3,  -1,  0,  30, 16'h0000, 2,  0,  0);
      tbl[8] = mk(5'd1,  1'b1, 0,  -1,  1,  -1, 16'h0000, 1,  1,  S + 6);

      rst = 1'b0;
      repeat (3) @(negedge clk_40_m);
      chk_all_zero("reset");
      rst = 1'b1;

      // Acks and trim_done while idle must not start anything
      @(negedge clk_40_m); spi_ack = 1'b1; trim_done = 1'b1;
      @(negedge clk_40_m); spi_ack = 1'b0; trim_done = 1'b0;
      @(negedge clk_40_m);
      chk("idle stray busy", 64'(busy), 64'd0);
      chk("idle stray spi_req", 64'(spi_req), 64'd0);

      // Reset asserted during SETTLE of bus 1
      n_buses = 5'd3; osc_auto_trim = 1'b0; start_init = 1'b1;
      @(negedge clk_40_m); start_init = 1'b0;
      got = 1'b0; ack_due = -1; prev = 1'b0;
      for (int c = 1; c < 3000 && !got; c++) begin
         spi_ack = 1'b0;
         if (spi_req && !prev) ack_due = c + 1;
         if (c == ack_due) spi_ack = 1'b1;
         if (prev && !spi_req && power_bus_cnt == 5'd1) got = 1'b1;
         prev = spi_req;
         if (!got) @(negedge clk_40_m);
      end
      spi_ack = 1'b0;
      chk("reached settle of bus 1", 64'(got), 64'd1);
      repeat (10) @(negedge clk_40_m);
      chk("busy in settle", 64'(busy), 64'd1);
      rst = 1'b0;
      @(negedge clk_40_m);
      chk_all_zero("mid-settle reset");
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         cur_vec = i;
         run_vec(tbl[i]);
      end
      cur_vec = -1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
